matrix_row_streamer: RTL and testbench

Transmit side of the 128-bit matrix row bus. On request, snapshots the four top-of-stack rows presented by `matrix_ctrl` and streams them one row per handshake to a downstream consumer (vertex transform / `matrix_row_comp` feeder). Row format matches the bus `matrix_ctrl` loads from: four IEEE-754 single-precision elements, element 0 in [127:96].

---
 rtl/matrix_pkg.sv | 16 +
 rtl/matrix_row_streamer_if.sv | 28 ++
 rtl/matrix_transpose_4x4.sv | 22 ++
 rtl/matrix_row_streamer.sv | 133 +++++++++++++
 tb/tb_matrix_row_streamer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix row bus (matrix_ctrl, matrix_row_streamer).
package matrix_pkg;

  localparam int unsigned ELEM_W      = 32;
  localparam int unsigned MATRIX_ROWS = 4;
  localparam int unsigned ROW_W       = MATRIX_ROWS * ELEM_W;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic MODE_MODELVIEW  = 1'b0;
  localparam logic MODE_PROJECTION = 1'b1;

endpackage

// File: rtl/matrix_row_streamer_if.sv
// Matrix row bus: one 128-bit row per valid/ready handshake.
interface matrix_row_streamer_if #(
  parameter int unsigned ROW_W = matrix_pkg::ROW_W
);

  logic [ROW_W-1:0] row_out;
  logic             row_valid;
  logic             row_ready;
  logic [1:0]       row_idx;
  logic             row_last;

  modport master (
    output row_out,
    output row_valid,
    output row_idx,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_out,
    input  row_valid,
    input  row_idx,
    input  row_last,
    output row_ready
  );

endinterface

// File: rtl/matrix_transpose_4x4.sv
// 4x4 element transpose of four 128-bit rows (element 0 in the top 32 bits).
// Only compiled when MATRIX_STREAM_TRANSPOSE_EN is defined.
`ifdef MATRIX_STREAM_TRANSPOSE_EN
module matrix_transpose_4x4 #(
  parameter int unsigned ELEM_W = matrix_pkg::ELEM_W
) (
  input  logic [3:0][ELEM_W-1:0] rows_in  [4],
  output logic [3:0][ELEM_W-1:0] cols_out [4]
);

  // Element i of row r sits at packed index 3-i; column j collects element j of every row.
  always_comb begin
    cols_out = '{default: '0};
    for (int unsigned j = 0; j < 4; j++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cols_out[j][3-i] = rows_in[i][3-j];
      end
    end
  end

endmodule
`endif

// File: rtl/matrix_row_streamer.sv
// Matrix row streamer: snapshots the four top-of-stack rows from matrix_ctrl
// on start and sends them one per handshake on the matrix row bus.
// Define MATRIX_STREAM_TRANSPOSE_EN to emit columns instead of rows.
module matrix_row_streamer #(
  parameter int unsigned ROW_W  = matrix_pkg::ROW_W,
  parameter int unsigned ELEM_W = matrix_pkg::ELEM_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   matrix_mode,
  input  logic [ROW_W-1:0]       peek_in_0,
  input  logic [ROW_W-1:0]       peek_in_1,
  input  logic [ROW_W-1:0]       peek_in_2,
  input  logic [ROW_W-1:0]       peek_in_3,
  matrix_row_streamer_if.master  row_bus,
  output logic                   mode_out,
  output logic                   busy,
  output logic                   done
);

  import matrix_pkg::MATRIX_ROWS;
  import matrix_pkg::state_t;
  import matrix_pkg::IDLE;
  import matrix_pkg::STREAM;
  import matrix_pkg::MODE_MODELVIEW;

  typedef logic [MATRIX_ROWS-1:0][ELEM_W-1:0] beat_t;

  state_t     state;
  state_t     state_next;
  beat_t      peek    [MATRIX_ROWS];
  beat_t      snap_in [MATRIX_ROWS];
  beat_t      snap    [MATRIX_ROWS];
  logic       capture;
  logic       advance;
  logic       finish;
  logic [1:0] row_idx_q;
  logic [1:0] row_idx_inc;
  logic [ROW_W-1:0] row_out_q;
  logic       row_last_q;

  assign peek[0] = peek_in_0;
  assign peek[1] = peek_in_1;
  assign peek[2] = peek_in_2;
  assign peek[3] = peek_in_3;

`ifdef MATRIX_STREAM_TRANSPOSE_EN
  matrix_transpose_4x4 #(
    .ELEM_W (ELEM_W)
  ) u_transpose (
    .rows_in  (peek),
    .cols_out (snap_in)
  );
`else
  assign snap_in = peek;
`endif

  assign row_idx_inc = row_idx_q + 2'd1;

  // Next state and one-cycle control strobes.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (row_bus.row_ready) begin
          if (row_idx_q == 2'd3) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Snapshot of the (optionally transposed) rows taken in the start cycle.
  always_ff @(posedge clk) begin
    if (rst)          snap <= '{default: '0};
    else if (capture) snap <= snap_in;
  end

  // Registered bus outputs; row_out is loaded ahead from the snapshot so it
  // never depends combinationally on row_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_out_q  <= '0;
      row_idx_q  <= '0;
      row_last_q <= 1'b0;
      mode_out   <= MODE_MODELVIEW;
      done       <= 1'b0;
    end else begin
      done <= finish;
      if (capture) begin
        row_out_q  <= snap_in[0];
        row_idx_q  <= '0;
        row_last_q <= 1'b0;
        mode_out   <= matrix_mode;
      end else if (advance) begin
        row_out_q  <= snap[row_idx_inc];
        row_idx_q  <= row_idx_inc;
        row_last_q <= (row_idx_inc == 2'd3);
      end else if (finish) begin
        row_idx_q  <= '0;
        row_last_q <= 1'b0;
      end
    end
  end

  assign row_bus.row_out   = row_out_q;
  assign row_bus.row_valid = (state == STREAM);
  assign row_bus.row_idx   = row_idx_q;
  assign row_bus.row_last  = row_last_q;
  assign busy              = (state == STREAM);

endmodule

// File: tb/tb_matrix_row_streamer.sv
// Directed testbench for matrix_row_streamer.
// Define MATRIX_STREAM_TRANSPOSE_EN to check the column-emitting build.
module tb_matrix_row_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         matrix_mode;
  logic [127:0] peek_in_0, peek_in_1, peek_in_2, peek_in_3;
  logic         mode_out, busy, done;

  matrix_row_streamer_if bus ();

  matrix_row_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .matrix_mode (matrix_mode),
    .peek_in_0   (peek_in_0),
    .peek_in_1   (peek_in_1),
    .peek_in_2   (peek_in_2),
    .peek_in_3   (peek_in_3),
    .row_bus     (bus),
    .mode_out    (mode_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] rows_ref [4];

  // Expected beat j for the given source rows.
  function automatic logic [127:0] exp_beat(input int unsigned j, input logic [127:0] r [4]);
`ifdef MATRIX_STREAM_TRANSPOSE_EN
    logic [127:0] col;
    col = {r[0][127-32*j -: 32], r[1][127-32*j -: 32], r[2][127-32*j -: 32], r[3][127-32*j -: 32]};
    return col;
`else
    return r[j];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rows();
    peek_in_0 = rows_ref[0];
    peek_in_1 = rows_ref[1];
    peek_in_2 = rows_ref[2];
    peek_in_3 = rows_ref[3];
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; matrix_mode = 1'b0; bus.row_ready = 1'b0;
    peek_in_0 = '0; peek_in_1 = '0; peek_in_2 = '0; peek_in_3 = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({bus.row_valid, busy, done, bus.row_idx, bus.row_last, mode_out} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {bus.row_valid, busy, done, bus.row_idx, bus.row_last, mode_out});
    end
    n_cmp++;
    if (bus.row_out !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_row_out: got %h want 0", bus.row_out);
    end
  endtask

  task automatic test_basic();
    drive_rows();
    bus.row_ready = 1'b1; matrix_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({bus.row_valid, busy, bus.row_idx, bus.row_last, mode_out, done} !==
          {1'b1, 1'b1, 2'(k), (k == 3), 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL basic_ctrl beat %0d: got %b want %b", k,
                 {bus.row_valid, busy, bus.row_idx, bus.row_last, mode_out, done},
                 {1'b1, 1'b1, 2'(k), (k == 3), 1'b0, 1'b0});
      end
      n_cmp++;
      if (bus.row_out !== exp_beat(k, rows_ref)) begin
        n_bad++;
        $display("FAIL basic_row beat %0d: got %h want %h", k, bus.row_out, exp_beat(k, rows_ref));
      end
      tick();
    end
    n_cmp++;
    if ({done, bus.row_valid, busy, mode_out} !== 4'b1000) begin
      n_bad++;
      $display("FAIL basic_done: got %b want 1000", {done, bus.row_valid, busy, mode_out});
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] idx_tab [6];
    logic       rdy_tab [6];
    idx_tab = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    rdy_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drive_rows();
    bus.row_ready = 1'b1; matrix_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.row_ready = rdy_tab[c];
      n_cmp++;
      if ({bus.row_valid, bus.row_idx, done} !== {1'b1, idx_tab[c], 1'b0} ||
          bus.row_out !== exp_beat(idx_tab[c], rows_ref)) begin
        n_bad++;
        $display("FAIL bp_cycle %0d: got v=%b idx=%0d done=%b row=%h want v=1 idx=%0d done=0 row=%h",
                 c + 1, bus.row_valid, bus.row_idx, done, bus.row_out,
                 idx_tab[c], exp_beat(idx_tab[c], rows_ref));
      end
      tick();
    end
    bus.row_ready = 1'b1;
    n_cmp++;
    if ({done, bus.row_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_done: got %b want 10", {done, bus.row_valid});
    end
    tick();
  endtask

  task automatic test_snapshot();
    drive_rows();
    bus.row_ready = 1'b1; matrix_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    matrix_mode = 1'b0;
    peek_in_2 = '1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (bus.row_out !== exp_beat(k, rows_ref) || mode_out !== 1'b1 || bus.row_idx !== 2'(k)) begin
        n_bad++;
        $display("FAIL snap beat %0d: got row=%h mode=%b idx=%0d want row=%h mode=1 idx=%0d",
                 k, bus.row_out, mode_out, bus.row_idx, exp_beat(k, rows_ref), k);
      end
      tick();
    end
    n_cmp++;
    if ({done, mode_out} !== 2'b11) begin
      n_bad++;
      $display("FAIL snap_done: got %b want 11", {done, mode_out});
    end
    peek_in_2 = rows_ref[2];
    tick();
  endtask

  task automatic test_start_handling();
    drive_rows();
    bus.row_ready = 1'b1; matrix_mode = 1'b0; start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({bus.row_valid, bus.row_idx} !== {1'b1, 2'(k)} || bus.row_out !== exp_beat(k, rows_ref)) begin
        n_bad++;
        $display("FAIL start_ignored beat %0d: got v=%b idx=%0d row=%h want v=1 idx=%0d row=%h",
                 k, bus.row_valid, bus.row_idx, bus.row_out, k, exp_beat(k, rows_ref));
      end
      tick();
    end
    n_cmp++;
    if ({done, bus.row_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL start_done_cycle: got %b want 10", {done, bus.row_valid});
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if ({bus.row_valid, bus.row_idx, done} !== 4'b1000 || bus.row_out !== exp_beat(0, rows_ref)) begin
      n_bad++;
      $display("FAIL start_restart: got v=%b idx=%0d done=%b row=%h want v=1 idx=0 done=0 row=%h",
               bus.row_valid, bus.row_idx, done, bus.row_out, exp_beat(0, rows_ref));
    end
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if ({done, bus.row_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL start_second_done: got %b want 10", {done, bus.row_valid});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive_rows();
    bus.row_ready = 1'b1; matrix_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if ({bus.row_valid, bus.row_idx, mode_out} !== 4'b1011) begin
      n_bad++;
      $display("FAIL rstmid_beat1: got %b want 1011", {bus.row_valid, bus.row_idx, mode_out});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({bus.row_valid, busy, done, bus.row_idx, bus.row_last, mode_out} !== 7'b0 ||
        bus.row_out !== 128'h0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got ctrl=%b row=%h want ctrl=0000000 row=0",
               {bus.row_valid, busy, done, bus.row_idx, bus.row_last, mode_out}, bus.row_out);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if ({done, bus.row_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL rstmid_idle cycle %0d: got %b want 00", c, {done, bus.row_valid});
      end
    end
  endtask

`ifdef MATRIX_STREAM_TRANSPOSE_EN
  task automatic test_transpose();
    peek_in_0 = 128'h3F800000_40000000_40400000_40800000;
    peek_in_1 = 128'h3F800000_40000000_40400000_40800000;
    peek_in_2 = 128'h3F800000_40000000_40400000_40800000;
    peek_in_3 = 128'h3F800000_40000000_40400000_40800000;
    bus.row_ready = 1'b1; matrix_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (bus.row_out !== 128'h3F800000_3F800000_3F800000_3F800000) begin
      n_bad++;
      $display("FAIL transpose_beat0: got %h want 3f8000003f8000003f8000003f800000", bus.row_out);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (bus.row_out !== 128'h40800000_40800000_40800000_40800000 || bus.row_idx !== 2'd3) begin
      n_bad++;
      $display("FAIL transpose_beat3: got %h idx=%0d want 40800000408000004080000040800000 idx=3",
               bus.row_out, bus.row_idx);
    end
    tick(); tick();
  endtask
`endif

  initial begin
    rows_ref[0] = 128'h3F800000_40000000_40400000_40800000;
    rows_ref[1] = 128'h3F800000_40000000_40400000_40800001;
    rows_ref[2] = 128'h3F800000_40000000_40400000_40800002;
    rows_ref[3] = 128'h3F800000_40000000_40400000_40800003;
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_start_handling();
    test_reset_mid();
`ifdef MATRIX_STREAM_TRANSPOSE_EN
    test_transpose();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
